// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for the RV32M multiply group (MUL, MULH,
// MULHSU, MULHU). Operands are reduced to magnitudes at accept, multiplied
// unsigned over WIDTH iterations, then the sign is reapplied in one cycle.
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | WIDTH shift-add iterations
// SIGN   | reapply product sign, register selected half
// DONE   | valid pulse; a new start is accepted here without a bubble
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [1:0]         op_q;
   logic               sign_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [WIDTH-1:0]   mplr_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   result_q;

   logic               accept;
   logic               last_iter;
   logic               s1_neg, s2_neg;
   logic [WIDTH-1:0]   s1_mag, s2_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_fin;

   assign accept    = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;
   assign last_iter = (cnt_q == CW'(WIDTH - 1));
   assign busy      = (state == S_CALC) || (state == S_SIGN);
   assign valid     = (state == S_DONE);
   assign result    = result_q;

   // Operand conditioning: the most negative value negates to itself and is
   // then read as the unsigned magnitude 2^(WIDTH-1), which is what we want.
   always_comb begin
      s1_neg = ((op == 2'b01) || (op == 2'b10)) && src1[WIDTH-1];
      s2_neg = (op == 2'b01) && src2[WIDTH-1];
      s1_mag = s1_neg ? ('0 - src1) : src1;
      s2_mag = s2_neg ? ('0 - src2) : src2;
   end

   // One shift-add step and the final sign fix-up.
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplr_q[0] ? mcand_q : '0)};
      acc_fin = sign_q ? ('0 - acc_q) : acc_q;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; flush wins over every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_CALC;
         S_CALC:  if (last_iter) state_nxt = S_SIGN;
         S_SIGN:  state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_CALC : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   // Datapath: load at accept, iterate in CALC, finish in SIGN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         sign_q   <= 1'b0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q    <= op;
         sign_q  <= s1_neg ^ s2_neg;
         mcand_q <= s1_mag;
         mplr_q  <= s2_mag;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (!flush && (state == S_CALC)) begin
         acc_q  <= {sum, acc_q[WIDTH-1:1]};
         mplr_q <= mplr_q >> 1;
         cnt_q  <= cnt_q + CW'(1);
      end else if (!flush && (state == S_SIGN)) begin
         acc_q    <= acc_fin;
         result_q <= (op_q == 2'b00) ? acc_fin[WIDTH-1:0] : acc_fin[2*WIDTH-1:WIDTH];
      end
   end

endmodule
